// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions: register-zero constant, mult/div FSM encoding and
// default mult/div latency, plus the nonzero register-match helper used by hazard logic.
package hazard_stall_unit_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int unsigned MD_LATENCY_DEFAULT = 8;

    typedef enum logic {StIdle, StBusy} md_state_e;

    // $0 is hardwired, so it can never carry a pending write.
    function automatic logic reg_match(logic [4:0] producer, logic [4:0] consumer);
        return (producer != REG_ZERO) && (producer == consumer);
    endfunction

endpackage

// File: rtl/hazard_stall_unit_md_busy_tracker.sv
// Mult/div busy tracker: holds md_busy for MD_LATENCY cycles after each start,
// reloading on a start that arrives while already busy.
module md_busy_tracker
    import hazard_stall_unit_pkg::*;
#(
    parameter int unsigned MD_LATENCY = MD_LATENCY_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic md_start,
    output logic md_busy
);

    localparam logic [3:0] LOAD_VAL = 4'(MD_LATENCY);

    md_state_e  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (md_start) begin
                    state_d = StBusy;
                    cnt_d   = LOAD_VAL;
                end
            end
            StBusy: begin
                // A restart takes precedence over the final countdown step.
                if (md_start) begin
                    cnt_d = LOAD_VAL;
                end else if (cnt_q == 4'd1) begin
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign md_busy = (state_q == StBusy);

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline interlock: stalls IF/ID on hazards forwarding cannot cover, flushes on
// taken control transfers, and counts stall cycles for performance analysis.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int unsigned MD_LATENCY = MD_LATENCY_DEFAULT,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       reg_rs_ID,
    input  logic [4:0]       reg_rt_ID,
    input  logic             uses_rt_ID,
    input  logic             branch_ID,
    input  logic             taken_ID,
    input  logic             mfhilo_ID,
    input  logic             md_op_ID,
    input  logic [4:0]       reg_wr_EX,
    input  logic             regwrite_EX,
    input  logic             memread_EX,
    input  logic             md_start_EX,
    input  logic [4:0]       reg_rd_MEM,
    input  logic             memread_MEM,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    logic lu, bex, bmem, md, stall;
    logic [CNT_W-1:0] stall_cnt_q;

    md_busy_tracker #(
        .MD_LATENCY (MD_LATENCY)
    ) u_md_busy_tracker (
        .clk      (clk),
        .rst_n    (rst_n),
        .md_start (md_start_EX),
        .md_busy  (md_busy)
    );

    always_comb begin
        lu   = memread_EX && (reg_match(reg_wr_EX, reg_rs_ID) ||
                              (uses_rt_ID && reg_match(reg_wr_EX, reg_rt_ID)));
        bex  = branch_ID && regwrite_EX &&
               (reg_match(reg_wr_EX, reg_rs_ID) || reg_match(reg_wr_EX, reg_rt_ID));
        bmem = branch_ID && memread_MEM &&
               (reg_match(reg_rd_MEM, reg_rs_ID) || reg_match(reg_rd_MEM, reg_rt_ID));
        md   = md_busy && (mfhilo_ID || md_op_ID);
        // Gated by rst_n so the pipeline controls read as "run" while reset is held.
        stall = rst_n && (lu || bex || bmem || md);
    end

    assign pc_write    = !stall;
    assign ifid_write  = !stall;
    assign idex_bubble = stall;
    assign ifid_flush  = rst_n && taken_ID && !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed pipeline scenarios followed by
// randomized traffic, all compared against a behavioural model of the interlock rules.
module tb_hazard_stall_unit;

    localparam int unsigned MD_LAT = 8;
    localparam int unsigned CW     = 4;
    localparam int          CMAX   = (1 << CW) - 1;

    logic clk, rst_n;
    logic [4:0] reg_rs_ID, reg_rt_ID, reg_wr_EX, reg_rd_MEM;
    logic uses_rt_ID, branch_ID, taken_ID, mfhilo_ID, md_op_ID;
    logic regwrite_EX, memread_EX, md_start_EX, memread_MEM;
    logic pc_write, ifid_write, idex_bubble, ifid_flush, md_busy;
    logic [CW-1:0] stall_cycles;

    int checks   = 0;
    int failures = 0;
    int busy_left;  // model: cycles of mult/div busy remaining
    int stall_cnt;  // model: saturating stall counter

    hazard_stall_unit #(
        .MD_LATENCY (MD_LAT),
        .CNT_W      (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .reg_rs_ID    (reg_rs_ID),
        .reg_rt_ID    (reg_rt_ID),
        .uses_rt_ID   (uses_rt_ID),
        .branch_ID    (branch_ID),
        .taken_ID     (taken_ID),
        .mfhilo_ID    (mfhilo_ID),
        .md_op_ID     (md_op_ID),
        .reg_wr_EX    (reg_wr_EX),
        .regwrite_EX  (regwrite_EX),
        .memread_EX   (memread_EX),
        .md_start_EX  (md_start_EX),
        .reg_rd_MEM   (reg_rd_MEM),
        .memread_MEM  (memread_MEM),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .idex_bubble  (idex_bubble),
        .ifid_flush   (ifid_flush),
        .md_busy      (md_busy),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic depends(input logic [4:0] dst, input logic [4:0] src);
        return dst != 5'd0 && dst == src;
    endfunction

    // Stall decision derived directly from the interlock rules.
    function automatic logic model_stall();
        logic reads_rs_rt_ex, branch_needs_ex, branch_needs_mem, md_wait;
        reads_rs_rt_ex   = depends(reg_wr_EX, reg_rs_ID) ||
                           (uses_rt_ID && depends(reg_wr_EX, reg_rt_ID));
        branch_needs_ex  = depends(reg_wr_EX, reg_rs_ID) || depends(reg_wr_EX, reg_rt_ID);
        branch_needs_mem = depends(reg_rd_MEM, reg_rs_ID) || depends(reg_rd_MEM, reg_rt_ID);
        md_wait          = (busy_left > 0) && (mfhilo_ID || md_op_ID);
        return (memread_EX && reads_rs_rt_ex) || (branch_ID && regwrite_EX && branch_needs_ex) ||
               (branch_ID && memread_MEM && branch_needs_mem) || md_wait;
    endfunction

    task automatic clear_inputs();
        reg_rs_ID = 5'd0; reg_rt_ID = 5'd0; reg_wr_EX = 5'd0; reg_rd_MEM = 5'd0;
        uses_rt_ID = 1'b0; branch_ID = 1'b0; taken_ID = 1'b0; mfhilo_ID = 1'b0;
        md_op_ID = 1'b0; regwrite_EX = 1'b0; memread_EX = 1'b0; md_start_EX = 1'b0;
        memread_MEM = 1'b0;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cycle(input string tag);
        logic s;
        #1;
        s = model_stall();
        chk({tag, ".pc_write"},    32'(pc_write),     32'(!s));
        chk({tag, ".ifid_write"},  32'(ifid_write),   32'(!s));
        chk({tag, ".idex_bubble"}, 32'(idex_bubble),  32'(s));
        chk({tag, ".ifid_flush"},  32'(ifid_flush),   32'(taken_ID && !s));
        chk({tag, ".md_busy"},     32'(md_busy),      32'(busy_left > 0));
        chk({tag, ".stall_cycles"}, 32'(stall_cycles), 32'(stall_cnt));
        @(posedge clk);
        if (md_start_EX) busy_left = MD_LAT;
        else if (busy_left > 0) busy_left--;
        if (s && stall_cnt < CMAX) stall_cnt++;
        @(negedge clk);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, ".rst_md_busy"},     32'(md_busy),      32'd0);
        chk({tag, ".rst_stall_cycles"}, 32'(stall_cycles), 32'd0);
        chk({tag, ".rst_pc_write"},    32'(pc_write),     32'd1);
        chk({tag, ".rst_ifid_write"},  32'(ifid_write),   32'd1);
        chk({tag, ".rst_idex_bubble"}, 32'(idex_bubble),  32'd0);
        chk({tag, ".rst_ifid_flush"},  32'(ifid_flush),   32'd0);
        busy_left = 0;
        stall_cnt = 0;
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        busy_left = 0;
        stall_cnt = 0;
        clear_inputs();

        // Reset with a hazard and a taken branch present on the inputs.
        @(negedge clk);
        memread_EX = 1'b1; reg_wr_EX = 5'd2; reg_rs_ID = 5'd2; taken_ID = 1'b1;
        pulse_reset("reset");
        clear_inputs();
        cycle("idle");

        // 1: load-use into an ALU op stalls exactly one cycle.
        memread_EX = 1'b1; regwrite_EX = 1'b1; reg_wr_EX = 5'd2; reg_rs_ID = 5'd2;
        #1 chk("t1.bubble", 32'(idex_bubble), 32'd1);
        cycle("t1.c0");
        memread_EX = 1'b0; regwrite_EX = 1'b0; reg_wr_EX = 5'd0;
        memread_MEM = 1'b1; reg_rd_MEM = 5'd2;
        #1 chk("t1.release", 32'(pc_write), 32'd1);
        cycle("t1.c1");

        // 2: load feeding a branch stalls two cycles, then the branch flushes.
        clear_inputs();
        memread_EX = 1'b1; regwrite_EX = 1'b1; reg_wr_EX = 5'd3;
        branch_ID = 1'b1; uses_rt_ID = 1'b1; reg_rt_ID = 5'd3; reg_rs_ID = 5'd1; taken_ID = 1'b1;
        #1 chk("t2.s0_flush", 32'(ifid_flush), 32'd0);
        cycle("t2.c0");
        memread_EX = 1'b0; regwrite_EX = 1'b0; reg_wr_EX = 5'd0;
        memread_MEM = 1'b1; reg_rd_MEM = 5'd3;
        #1 chk("t2.s1_bubble", 32'(idex_bubble), 32'd1);
        cycle("t2.c1");
        memread_MEM = 1'b0; reg_rd_MEM = 5'd0;
        #1 chk("t2.flush", 32'(ifid_flush), 32'd1);
        cycle("t2.c2");

        // 4: load-use coinciding with a taken jump: stall wins, flush follows.
        clear_inputs();
        memread_EX = 1'b1; regwrite_EX = 1'b1; reg_wr_EX = 5'd5; reg_rs_ID = 5'd5; taken_ID = 1'b1;
        #1 chk("t4.noflush", 32'(ifid_flush), 32'd0);
        cycle("t4.c0");
        memread_EX = 1'b0; regwrite_EX = 1'b0; reg_wr_EX = 5'd0;
        memread_MEM = 1'b1; reg_rd_MEM = 5'd5;
        #1 chk("t4.flush", 32'(ifid_flush), 32'd1);
        cycle("t4.c1");

        // 5a: dependencies through $0 never stall.
        clear_inputs();
        memread_EX = 1'b1; regwrite_EX = 1'b1; branch_ID = 1'b1; uses_rt_ID = 1'b1;
        memread_MEM = 1'b1;
        #1 chk("t5.zero", 32'(pc_write), 32'd1);
        cycle("t5.zero");

        // 3: mflo behind a mult waits out the full latency.
        clear_inputs();
        md_start_EX = 1'b1;
        cycle("t3.start");
        md_start_EX = 1'b0; mfhilo_ID = 1'b1;
        for (int i = 0; i < int'(MD_LAT); i++) begin
            #1 chk("t3.busy_stall", 32'(pc_write), 32'd0);
            cycle("t3.wait");
        end
        #1 chk("t3.released", 32'(md_busy), 32'd0);
        cycle("t3.done");

        // Randomized traffic over a small register range to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            reg_rs_ID   = 5'($urandom_range(0, 3));
            reg_rt_ID   = 5'($urandom_range(0, 3));
            reg_wr_EX   = 5'($urandom_range(0, 3));
            reg_rd_MEM  = 5'($urandom_range(0, 3));
            uses_rt_ID  = 1'($urandom_range(0, 1));
            branch_ID   = 1'($urandom_range(0, 1));
            taken_ID    = 1'($urandom_range(0, 1));
            mfhilo_ID   = ($urandom_range(0, 3) == 0);
            md_op_ID    = ($urandom_range(0, 5) == 0);
            regwrite_EX = 1'($urandom_range(0, 1));
            memread_EX  = ($urandom_range(0, 2) == 0);
            memread_MEM = ($urandom_range(0, 2) == 0);
            md_start_EX = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 63) == 0) pulse_reset("rand");
            cycle("rand");
        end

        // 5b: stall counter saturates at all-ones.
        clear_inputs();
        pulse_reset("sat");
        memread_EX = 1'b1; reg_wr_EX = 5'd7; reg_rs_ID = 5'd7;
        for (int i = 0; i < CMAX; i++) cycle("sat.fill");
        #1 chk("t5.at_max", 32'(stall_cycles), 32'(CMAX));
        for (int i = 0; i < 4; i++) cycle("sat.hold");
        #1 chk("t5.saturated", 32'(stall_cycles), 32'(CMAX));

        // 6: asynchronous reset mid-busy clears state immediately.
        clear_inputs();
        md_start_EX = 1'b1;
        cycle("t6.start");
        md_start_EX = 1'b0; mfhilo_ID = 1'b1;
        for (int i = 0; i < 3; i++) cycle("t6.busy");
        #1 chk("t6.busy_before", 32'(md_busy), 32'd1);
        pulse_reset("t6");
        cycle("t6.after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
